// File: rtl/qarctan_pkg.sv
// Shared types and helpers for the quadrature-arctan stream block.
// - qarctan_state_t : control FSM states.
// - *_Q10 constants : default angle constants at FRAC_BITS=10 (pi = 3217).
// - dequantize()    : arithmetic right shift that rounds toward zero.
package qarctan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    SCALE,
    OUT
  } qarctan_state_t;

  localparam int QUAD_ONE_Q10   = 804;   // pi/4
  localparam int QUAD_THREE_Q10 = 2412;  // 3pi/4
  localparam int ZERO_ANGLE_Q10 = 1608;  // result for x==0 && y==0

  // Shift right by frac, rounding toward zero. A plain >>> floors, so
  // negative values get a (2^frac - 1) bias first. Operates on 64 bits,
  // which covers the product width for DATA_WIDTH up to about 40.
  function automatic logic signed [63:0] dequantize(input logic signed [63:0] value,
                                                    input int                 frac);
    logic signed [63:0] bias;
    bias = value[63] ? ((64'sd1 <<< frac) - 64'sd1) : 64'sd0;
    return (value + bias) >>> frac;
  endfunction

endpackage

// File: rtl/qarctan_stream_sdiv.sv
// Radix-2 restoring signed divider, one quotient bit per clock.
// Divides magnitudes, then applies the sign of (dividend ^ divisor) to the
// quotient (truncation toward zero).
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears control only)
//   start      : load operands; ignored while an operation is in flight
//   dividend   : signed DIVIDEND_W-bit dividend
//   divisor    : signed DIVISOR_W-bit divisor (must be non-zero)
//   quotient   : signed DIVIDEND_W-bit quotient, valid from done onward
//   done       : one-cycle pulse; high during the cycle ending at the
//                (DIVIDEND_W+1)-th edge after the start edge
module qarctan_sdiv #(
  parameter int DIVIDEND_W = 44,
  parameter int DIVISOR_W  = 34
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic signed [DIVIDEND_W-1:0] quotient,
  output logic                         done
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  logic                  busy;
  logic [CW-1:0]         cnt;
  logic                  load;

  // dvd_q shifts the dividend out at the top while quotient bits enter at
  // the bottom, so after DIVIDEND_W steps it holds the quotient magnitude.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  neg_q;

  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W:0]    diff;
  logic [DIVIDEND_W-1:0] dvd_next;
  logic [DIVISOR_W-1:0]  rem_next;
  logic                  last;

  assign load    = start && !busy;
  assign last    = busy && (cnt == CW'(1));
  assign dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign dvs_mag = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

  // rem < divisor always, so the shifted remainder fits in DIVISOR_W+1 bits
  // and the top bit of the difference is a valid borrow flag.
  always_comb begin
    rem_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    if (!diff[DIVISOR_W]) begin
      rem_next = diff[DIVISOR_W-1:0];
      dvd_next = {dvd_q[DIVIDEND_W-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[DIVISOR_W-1:0];
      dvd_next = {dvd_q[DIVIDEND_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        busy <= 1'b1;
        cnt  <= CW'(DIVIDEND_W);
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      dvd_q <= dvd_mag;
      dvs_q <= dvs_mag;
      rem_q <= '0;
      neg_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
    end else if (busy) begin
      dvd_q <= dvd_next;
      rem_q <= rem_next;
      if (last) begin
        quotient <= neg_q ? -dvd_next : dvd_next;
      end
    end
  end

endmodule

// File: rtl/qarctan_stream.sv
// Streaming fixed-point approximation of angle(x + jy) with valid/ready on
// both sides. Output units: pi = 3217 at FRAC_BITS = 10.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready is high only in IDLE
//   x, y                 : signed real / imaginary parts
//   out_valid / out_ready: output handshake; out_angle held while stalled
//   out_angle            : signed angle
//   busy                 : high in every state except IDLE
module qarctan_stream
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int QUAD_ONE   = QUAD_ONE_Q10,
  parameter int QUAD_THREE = QUAD_THREE_Q10,
  parameter int ZERO_ANGLE = ZERO_ANGLE_Q10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_angle,
  output logic                         busy
);

  localparam int IW = DATA_WIDTH + 2;
  localparam int QW = IW + FRAC_BITS;
  localparam int PW = QW + 12;
  localparam logic signed [PW-1:0] QUAD_ONE_W = PW'(QUAD_ONE);

  qarctan_state_t state;

  logic signed [DATA_WIDTH-1:0] x_p0;
  logic signed [DATA_WIDTH-1:0] y_p0;

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] abs_y;
  logic signed [IW-1:0] num;
  logic signed [IW-1:0] den;
  logic signed [QW-1:0] dividend;
  logic                 div_start;
  logic signed [QW-1:0] quot_p1;
  logic                 div_done;

  logic signed [PW-1:0]         prod;
  logic signed [63:0]           deq;
  logic signed [63:0]           ang;
  logic signed [DATA_WIDTH-1:0] angle_next;
  logic                         xy_zero;

  // Stage p0: operands captured on the accept edge
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      x_p0 <= x;
      y_p0 <= y;
    end
  end

  // Two guard bits keep |y|+1 and x +/- abs_y from overflowing.
  always_comb begin
    x_ext = {{2{x_p0[DATA_WIDTH-1]}}, x_p0};
    y_ext = {{2{y_p0[DATA_WIDTH-1]}}, y_p0};
    abs_y = (y_p0[DATA_WIDTH-1] ? -y_ext : y_ext) + IW'(1);
    if (!x_p0[DATA_WIDTH-1]) begin
      num = x_ext - abs_y;
      den = x_ext + abs_y;
    end else begin
      num = x_ext + abs_y;
      den = abs_y - x_ext;
    end
    dividend = {num, {FRAC_BITS{1'b0}}};
  end

  assign div_start = (state == PREP);

  // Stage p1: quotient r = (num <<< FRAC_BITS) / den, |r| <= 2^FRAC_BITS
  qarctan_sdiv #(
    .DIVIDEND_W(QW),
    .DIVISOR_W (IW)
  ) u_sdiv (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(dividend),
    .divisor (den),
    .quotient(quot_p1),
    .done    (div_done)
  );

  // Stage p2: scale, dequantise, pick quadrant offset, apply y sign
  always_comb begin
    xy_zero = (x_p0 == '0) && (y_p0 == '0);
    prod    = {{(PW - QW){quot_p1[QW-1]}}, quot_p1} * QUAD_ONE_W;
    deq     = dequantize(64'(prod), FRAC_BITS);
    if (xy_zero) begin
      ang = 64'(ZERO_ANGLE);
    end else if (!x_p0[DATA_WIDTH-1]) begin
      ang = 64'(QUAD_ONE) - deq;
    end else begin
      ang = 64'(QUAD_THREE) - deq;
    end
    angle_next = DATA_WIDTH'(y_p0[DATA_WIDTH-1] ? -ang : ang);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_angle <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= PREP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        PREP: begin
          state <= DIV;
        end
        DIV: begin
          if (div_done) begin
            state <= SCALE;
          end
        end
        SCALE: begin
          out_angle <= angle_next;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
